// File: rtl/loopback_fifo_pkg.sv
// Shared encodings for the loopback FIFO: per-channel transform modes and release FSM states.
package loopback_fifo_pkg;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_INV  = 2'b01;
  localparam logic [1:0] MODE_REV  = 2'b10;
  localparam logic [1:0] MODE_DROP = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StFill  = 2'b01,
    StDrain = 2'b10
  } state_e;

endpackage

// File: rtl/loopback_fifo_chan.sv
// One loopback channel: write transform, FWFT FIFO and burst release FSM with idle timer.
// Optional per-channel traffic counters when LOOPBACK_FIFO_STATS_EN is defined.
module loopback_fifo_chan
  import loopback_fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned THRESHOLD = 8,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] out_data_i,
  input  logic             out_valid_i,
  output logic             out_ready_o,
  output logic [WIDTH-1:0] in_data_o,
  output logic             in_valid_o,
  input  logic             in_ready_i,
  input  logic [1:0]       mode_i
`ifdef LOOPBACK_FIFO_STATS_EN
  ,
  output logic [31:0]      rx_count_o,
  output logic [31:0]      tx_count_o
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TimerMax = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CntFull  = CW'(DEPTH);
  localparam logic [CW-1:0] CntThr   = CW'(THRESHOLD);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic [TW-1:0]    timer_q, timer_d;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] wdata;
  logic             full, empty, wr, store, rd;

  assign full  = (count_q == CntFull);
  assign empty = (count_q == '0);

  // Ready is gated by reset so the port reads low while rst_i is held.
  assign out_ready_o = ~rst_i & ~full;
  assign in_valid_o  = (state_q == StDrain) & ~empty;
  assign in_data_o   = empty ? '0 : mem[rd_ptr_q];

  assign wr    = out_valid_i & out_ready_o;
  assign store = wr & (mode_i != MODE_DROP);
  assign rd    = in_valid_o & in_ready_i;

  always_comb begin
    wdata = out_data_i;
    case (mode_i)
      MODE_INV: wdata = ~out_data_i;
      MODE_REV: begin
        for (int i = 0; i < int'(WIDTH); i++) begin
          wdata[i] = out_data_i[WIDTH-1-i];
        end
      end
      default: wdata = out_data_i;
    endcase
  end

  assign count_d = count_q + CW'(store) - CW'(rd);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      StIdle: begin
        if (store) begin
          state_d = StFill;
          timer_d = '0;
        end
      end
      StFill: begin
        if (wr) begin
          timer_d = '0;
        end else if (timer_q != TimerMax) begin
          timer_d = timer_q + 1'b1;
        end
        if ((count_d >= CntThr) || (count_d == CntFull) || (timer_q == TimerMax)) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        timer_d = '0;
        // Leaving only once nothing is buffered keeps late writes in the current burst.
        if (count_d == '0) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      count_q <= count_d;
      if (store) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd)    rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (store) mem[wr_ptr_q] <= wdata;
  end

`ifdef LOOPBACK_FIFO_STATS_EN
  logic [31:0] rx_q, tx_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_q <= '0;
      tx_q <= '0;
    end else begin
      if (store) rx_q <= rx_q + 32'd1;
      if (rd)    tx_q <= tx_q + 32'd1;
    end
  end

  assign rx_count_o = rx_q;
  assign tx_count_o = tx_q;
`endif

endmodule

// File: rtl/loopback_fifo.sv
// USB loopback buffer: CHANNELS independent transform + burst FIFO channels.
// Define LOOPBACK_FIFO_STATS_EN to add rx_count_o/tx_count_o traffic counters.
module loopback_fifo
  import loopback_fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned CHANNELS  = 1,
  parameter int unsigned THRESHOLD = 8,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [CHANNELS*WIDTH-1:0] out_data_i,
  input  logic [CHANNELS-1:0]       out_valid_i,
  output logic [CHANNELS-1:0]       out_ready_o,
  output logic [CHANNELS*WIDTH-1:0] in_data_o,
  output logic [CHANNELS-1:0]       in_valid_o,
  input  logic [CHANNELS-1:0]       in_ready_i,
  input  logic [2*CHANNELS-1:0]     mode_i
`ifdef LOOPBACK_FIFO_STATS_EN
  ,
  output logic [32*CHANNELS-1:0]    rx_count_o,
  output logic [32*CHANNELS-1:0]    tx_count_o
`endif
);

  for (genvar c = 0; c < int'(CHANNELS); c++) begin : g_chan
    loopback_fifo_chan #(
      .WIDTH     (WIDTH),
      .DEPTH     (DEPTH),
      .THRESHOLD (THRESHOLD),
      .TIMEOUT   (TIMEOUT)
    ) u_chan (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .out_data_i  (out_data_i[c*WIDTH +: WIDTH]),
      .out_valid_i (out_valid_i[c]),
      .out_ready_o (out_ready_o[c]),
      .in_data_o   (in_data_o[c*WIDTH +: WIDTH]),
      .in_valid_o  (in_valid_o[c]),
      .in_ready_i  (in_ready_i[c]),
      .mode_i      (mode_i[2*c +: 2])
`ifdef LOOPBACK_FIFO_STATS_EN
      ,
      .rx_count_o  (rx_count_o[32*c +: 32]),
      .tx_count_o  (tx_count_o[32*c +: 32])
`endif
    );
  end

endmodule

// File: tb/tb_loopback_fifo.sv
// Directed bench for loopback_fifo: two channels, DEPTH=16, THRESHOLD=8, TIMEOUT=16.
module tb_loopback_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] out_data;
  logic [1:0]  out_valid;
  logic [1:0]  out_ready;
  logic [15:0] in_data;
  logic [1:0]  in_valid;
  logic [1:0]  in_ready;
  logic [3:0]  mode;

  int total = 0;
  int bad   = 0;
  logic [7:0] rx0[$];
  logic [7:0] rx1[$];
  int acc0, acc1;
  bit seen0, seen1;

  always #5 clk = ~clk;

  loopback_fifo #(
    .WIDTH     (8),
    .DEPTH     (16),
    .CHANNELS  (2),
    .THRESHOLD (8),
    .TIMEOUT   (16)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .out_data_i  (out_data),
    .out_valid_i (out_valid),
    .out_ready_o (out_ready),
    .in_data_o   (in_data),
    .in_valid_o  (in_valid),
    .in_ready_i  (in_ready),
    .mode_i      (mode)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Records handshakes that the coming edge will perform, then advances one cycle.
  task automatic tick();
    if (!rst) begin
      if (in_valid[0] && in_ready[0]) rx0.push_back(in_data[7:0]);
      if (in_valid[1] && in_ready[1]) rx1.push_back(in_data[15:8]);
      if (out_valid[0] && out_ready[0]) acc0++;
      if (out_valid[1] && out_ready[1]) acc1++;
      if (in_valid[0]) seen0 = 1'b1;
      if (in_valid[1]) seen1 = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_log();
    rx0.delete();
    rx1.delete();
    acc0  = 0;
    acc1  = 0;
    seen0 = 1'b0;
    seen1 = 1'b0;
  endtask

  function automatic logic [7:0] rx0_at(input int i);
    return (i < rx0.size()) ? rx0[i] : 8'h00;
  endfunction

  task automatic wait_rx0(input int n, input int budget, input string tag);
    int k = 0;
    while (rx0.size() < n && k < budget) begin
      tick();
      k++;
    end
    check(tag, rx0.size(), n);
  endtask

  task automatic wait_rx1(input int n, input int budget, input string tag);
    int k = 0;
    while (rx1.size() < n && k < budget) begin
      tick();
      k++;
    end
    check(tag, rx1.size(), n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nv;
    int na5;
    rst       = 1'b1;
    out_valid = '0;
    out_data  = '0;
    in_ready  = '0;
    mode      = '0;
    clear_log();
    @(negedge clk);
    tick();
    tick();

    // Reset state
    check("rst_out_ready", out_ready, 2'b00);
    check("rst_in_valid", in_valid, 2'b00);
    check("rst_in_data", in_data, 16'h0000);
    rst = 1'b0;
    #1;
    check("post_rst_ready", out_ready, 2'b11);

    // Partial burst released by timeout
    clear_log();
    in_ready = 2'b11;
    for (int i = 1; i <= 7; i++) begin
      out_valid = 2'b01;
      out_data  = {8'h00, 8'(i)};
      tick();
    end
    out_valid = '0;
    nv = 0;
    for (int k = 0; k < 15; k++) begin
      if (in_valid[0]) nv++;
      tick();
    end
    check("t1_hold", nv, 0);
    wait_rx0(7, 40, "t1_count");
    for (int i = 0; i < 7; i++) check("t1_data", rx0_at(i), 32'(i + 1));
    tick();
    check("t1_idle", in_valid[0], 1'b0);

    // Threshold release on the 8th write, contiguous drain
    clear_log();
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("t2_pre", in_valid[0], 1'b0);
      out_valid = 2'b01;
      out_data  = {8'h00, 8'(8'h11 + i)};
      tick();
    end
    out_valid = '0;
    check("t2_drain", in_valid[0], 1'b1);
    for (int k = 0; k < 8; k++) tick();
    check("t2_contig", rx0.size(), 8);
    for (int i = 0; i < 8; i++) check("t2_data", rx0_at(i), 32'(8'h11 + i));

    // Transforms: invert then bit-reverse
    clear_log();
    out_valid = 2'b01;
    mode      = 4'b0001;
    out_data  = 16'h000F;
    tick();
    mode      = 4'b0010;
    out_data  = 16'h0001;
    tick();
    out_valid = '0;
    mode      = '0;
    wait_rx0(2, 40, "t3_count");
    check("t3_inv", rx0_at(0), 8'hF0);
    check("t3_rev", rx0_at(1), 8'h80);

    // Full FIFO backpressure
    clear_log();
    in_ready = 2'b00;
    for (int i = 0; i < 20; i++) begin
      out_valid = 2'b01;
      out_data  = {8'h00, 8'(8'h20 + i)};
      tick();
    end
    out_valid = '0;
    check("t4_accepted", acc0, 16);
    check("t4_full_ready", out_ready[0], 1'b0);
    in_ready = 2'b11;
    wait_rx0(16, 40, "t4_count");
    for (int i = 0; i < 16; i++) check("t4_data", rx0_at(i), 32'(8'h20 + i));
    check("t4_ready_back", out_ready[0], 1'b1);
    for (int k = 0; k < 5; k++) tick();
    check("t4_exact", rx0.size(), 16);

    // Channel independence: ch0 discards, ch1 echoes
    clear_log();
    mode      = 4'b0011;
    out_data  = 16'hA5A5;
    out_valid = 2'b11;
    for (int k = 0; k < 10; k++) tick();
    out_valid = '0;
    wait_rx1(10, 40, "t5_ch1_count");
    check("t5_ch0_accept", acc0, 10);
    check("t5_ch0_valid", seen0, 1'b0);
    check("t5_ch0_rx", rx0.size(), 0);
    na5 = 0;
    foreach (rx1[i]) if (rx1[i] == 8'hA5) na5++;
    check("t5_ch1_data", na5, 10);
    mode = '0;

    // Reset mid-burst
    clear_log();
    in_ready = 2'b00;
    for (int i = 0; i < 8; i++) begin
      out_valid = 2'b01;
      out_data  = {8'h00, 8'(8'h40 + i)};
      tick();
    end
    out_valid = '0;
    in_ready  = 2'b11;
    for (int k = 0; k < 5; k++) tick();
    check("t6_partial", rx0.size(), 5);
    rst = 1'b1;
    tick();
    check("t6_rst_valid", in_valid[0], 1'b0);
    check("t6_rst_data", in_data[7:0], 8'h00);
    rst = 1'b0;
    #1;
    check("t6_ready", out_ready, 2'b11);
    check("t6_empty", in_valid, 2'b00);
    clear_log();
    for (int i = 0; i < 8; i++) begin
      out_valid = 2'b01;
      out_data  = {8'h00, 8'(8'h50 + i)};
      tick();
    end
    out_valid = '0;
    wait_rx0(8, 40, "t6_count");
    for (int i = 0; i < 8; i++) check("t6_data", rx0_at(i), 32'(8'h50 + i));
    for (int k = 0; k < 3; k++) tick();
    check("t6_exact", rx0.size(), 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/loopback_fifo.md
LOOPBACK_FIFO -- requirements
Module: loopback_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data byte width in bits per channel.
REQ-002 Parameter DEPTH, default 64, FIFO entries per channel; power of 2, minimum 4.
REQ-003 Parameter CHANNELS, default 1, number of independent loopback channels (1..4).
REQ-004 Parameter THRESHOLD, default 8, fill level in entries that releases a burst; 1..DEPTH.
REQ-005 Parameter TIMEOUT, default 1024, idle cycles after which a partial burst is released; minimum 2.
REQ-006 clk_i  input  1  single clock; every register is on its rising edge.
REQ-007 rst_i  input  1  synchronous, active-high reset.
REQ-008 out_data_i  input  CHANNELS*WIDTH  bytes from the USB OUT endpoints; channel c occupies bits [c*WIDTH +: WIDTH].
REQ-009 out_valid_i  input  CHANNELS  per-channel write request.
REQ-010 out_ready_o  output  CHANNELS  per-channel write accept.
REQ-011 in_data_o  output  CHANNELS*WIDTH  bytes to the USB IN endpoints.
REQ-012 in_valid_o  output  CHANNELS  per-channel read data available.
REQ-013 in_ready_i  input  CHANNELS  per-channel read accept.
REQ-014 mode_i  input  2*CHANNELS  per-channel transform: 00 pass, 01 ones-complement, 10 bit-reverse, 11 discard.

Function
REQ-015 A write occurs on a cycle where out_valid_i[c] and out_ready_o[c] are both high; a read occurs where in_valid_o[c] and in_ready_i[c] are both high.
REQ-016 out_ready_o[c] shall be high when the channel FIFO is not full; a write is never accepted into a full FIFO, including on a cycle that also reads.
REQ-017 The transform selected by mode_i is sampled on the write cycle and applied before storage; a mode change affects only later writes.
REQ-018 Mode 11 shall accept writes (out_ready_o high) but store nothing.
REQ-019 Each channel has a three-state release FSM: IDLE, FILL, DRAIN.
REQ-020 From IDLE, a storing write moves the FSM to FILL and clears the idle timer.
REQ-021 From FILL, the FSM moves to DRAIN when the post-update count is at least THRESHOLD, or the FIFO is full, or the idle timer reaches TIMEOUT-1.
REQ-022 In DRAIN, a read that empties the FIFO with no simultaneous write moves the FSM to IDLE.
REQ-023 In FILL, the idle timer increments each cycle without a write and clears on every write; the timer saturates and never wraps.
REQ-024 in_valid_o[c] shall be high only in DRAIN with the FIFO not empty.
REQ-025 in_data_o[c] presents the FIFO head first-word-fall-through, with one-cycle latency from the storing write to visibility at the head.
REQ-026 Writes continue to be accepted during DRAIN and are drained in the same burst.
REQ-027 Simultaneous read and write on a non-full FIFO leaves the count unchanged.
REQ-028 Pointers are log2(DEPTH) bits, wrap modulo DEPTH, with a separate log2(DEPTH)+1-bit count.
REQ-029 Channels are fully independent; no channel's state affects another's.

Reset
REQ-030 While rst_i is high, at the clock edge: all FIFOs empty, FSMs in IDLE, timers cleared, out_ready_o=0, in_valid_o=0, in_data_o=0.
REQ-031 On the first cycle after rst_i falls, out_ready_o shall be all ones.
REQ-032 Reset asserted mid-burst discards all buffered data, with no partial output afterwards.

Configuration
REQ-033 With macro LOOPBACK_FIFO_STATS_EN defined, the module adds ports rx_count_o and tx_count_o (32*CHANNELS each): per-channel counters of storing writes and reads, cleared by rst_i, wrapping at 2^32.
REQ-034 Without LOOPBACK_FIFO_STATS_EN, those ports and counters shall not exist; all other behaviour is identical.

Structure
REQ-035 Package loopback_fifo_pkg holds the mode encodings (MODE_PASS, MODE_INV, MODE_REV, MODE_DROP) and the FSM state encodings.
REQ-036 Sub-module loopback_fifo_chan implements one channel (FIFO, transform, FSM, timer); the top instantiates CHANNELS copies in a generate loop.

Verification
REQ-037 Write 0x01..0x07 with mode 00, THRESHOLD=8, TIMEOUT=16, in_ready high -> no in_valid for 15 idle cycles, then 0x01..0x07 out in order.
REQ-038 Write 0x11..0x18, mode 00 -> DRAIN entered on the 8th write; 0x11..0x18 read back contiguously.
REQ-039 Mode 01 write 0x0F, then mode 10 write 0x01, then timeout -> outputs 0xF0, 0x80.
REQ-040 DEPTH=16, in_ready low, write 20 bytes -> out_ready low after 16 accepted; after in_ready rises, exactly 16 bytes out and out_ready reasserts.
REQ-041 CHANNELS=2, ch0 mode 11 and ch1 mode 00, both streaming 0xA5 -> ch0 in_valid never asserts; ch1 echoes 0xA5.
REQ-042 Assert rst_i after 5 of 8 bytes are drained -> in_valid low next cycle; after release, FIFO empty and the next burst contains only new data.
